// File: rtl/tvm_vpi_dma_pkg.sv
// Shared state encoding and lane-sizing helpers for the VPI read DMA.
package tvm_vpi_dma_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    STREAM,
    DRAIN
  } dma_state_e;

  function automatic int calc_lanes(input int out_width, input int read_width);
    return out_width / read_width;
  endfunction

  // Lane count must represent 0..LANES inclusive.
  function automatic int calc_lane_cnt_w(input int lanes);
    return $clog2(lanes) + 1;
  endfunction

endpackage

// File: rtl/tvm_vpi_pack_reg.sv
// Lane packer feeding a one-entry output register on a valid/ready stream.
// The pack register empties in the same cycle it transfers, so it can refill without a bubble.
module tvm_vpi_pack_reg
  import tvm_vpi_dma_pkg::*;
#(
  parameter int  READ_WIDTH = 8,
  parameter int  OUT_WIDTH  = 32,
  localparam int LANES      = calc_lanes(OUT_WIDTH, READ_WIDTH),
  localparam int LCW        = calc_lane_cnt_w(LANES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  consume,
  input  logic [READ_WIDTH-1:0] elem,
  input  logic                  final_elem,
  input  logic                  out_ready,
  output logic                  pack_full,
  output logic                  xfer,
  output logic                  out_valid,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic [LCW-1:0]        out_lanes,
  output logic                  out_last
);

  localparam logic [LCW-1:0] FULL_CNT = LCW'(LANES);

  logic [OUT_WIDTH-1:0] pack_data_q, pack_data_d;
  logic [LCW-1:0]       pack_cnt_q, pack_cnt_d;
  logic                 pack_last_q, pack_last_d;
  logic                 out_valid_q, out_valid_d;
  logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
  logic [LCW-1:0]       out_lanes_q, out_lanes_d;
  logic                 out_last_q, out_last_d;
  logic [LCW-1:0]       base_cnt;

  assign pack_full = (pack_cnt_q == FULL_CNT) || pack_last_q;
  assign xfer      = pack_full && (!out_valid_q || out_ready);

  always_comb begin
    pack_data_d = pack_data_q;
    pack_cnt_d  = pack_cnt_q;
    pack_last_d = pack_last_q;
    if (xfer) begin
      pack_data_d = '0;
      pack_cnt_d  = '0;
      pack_last_d = 1'b0;
    end
    base_cnt = pack_cnt_d;
    if (consume) begin
      for (int l = 0; l < LANES; l++) begin
        if (base_cnt == LCW'(l)) begin
          pack_data_d[l*READ_WIDTH +: READ_WIDTH] = elem;
        end
      end
      pack_cnt_d  = base_cnt + LCW'(1);
      pack_last_d = final_elem;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_lanes_d = out_lanes_q;
    out_last_d  = out_last_q;
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = pack_data_q;
      out_lanes_d = pack_cnt_q;
      out_last_d  = pack_last_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pack_data_q <= '0;
      pack_cnt_q  <= '0;
      pack_last_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_lanes_q <= '0;
      out_last_q  <= 1'b0;
    end else begin
      pack_data_q <= pack_data_d;
      pack_cnt_q  <= pack_cnt_d;
      pack_last_q <= pack_last_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_lanes_q <= out_lanes_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_lanes = out_lanes_q;
  assign out_last  = out_last_q;

endmodule

// File: rtl/tvm_vpi_read_dma.sv
// Read DMA: one host read request per command, then packs the returned element stream into words.
// state  | meaning
// IDLE   | waiting for a command, cmd_ready high
// REQ    | host_read_req pulse with latched address/size
// STREAM | pulling elements until the final word reaches the output register
// DRAIN  | waiting for the last word to be accepted (or zero-size completion)
module tvm_vpi_read_dma
  import tvm_vpi_dma_pkg::*;
#(
  parameter int  READ_WIDTH = 8,
  parameter int  OUT_WIDTH  = 32,
  parameter int  ADDR_WIDTH = 32,
  parameter int  SIZE_WIDTH = 32,
  localparam int LANES      = calc_lanes(OUT_WIDTH, READ_WIDTH),
  localparam int LCW        = calc_lane_cnt_w(LANES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [SIZE_WIDTH-1:0] cmd_size,
  output logic                  host_read_req,
  output logic [ADDR_WIDTH-1:0] host_read_addr,
  output logic [SIZE_WIDTH-1:0] host_read_size,
  output logic                  read_en,
  input  logic [READ_WIDTH-1:0] read_data_in,
  input  logic                  read_data_valid,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic [LCW-1:0]        out_lanes,
  output logic                  out_last,
  output logic                  done
);

  dma_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [SIZE_WIDTH-1:0] size_q, size_d;
  logic [SIZE_WIDTH-1:0] remaining_q, remaining_d;
  logic                  done_q, done_d;
  logic                  pack_full;
  logic                  xfer;
  logic                  consume;
  logic                  final_elem;

  assign cmd_ready      = (state_q == IDLE);
  assign host_read_req  = (state_q == REQ);
  assign host_read_addr = addr_q;
  assign host_read_size = size_q;
  assign done           = done_q;

  // A full pack register that is transferring this cycle can still take an element.
  assign read_en    = (state_q == STREAM) && (remaining_q != '0) && (!pack_full || xfer);
  assign consume    = read_en && read_data_valid;
  assign final_elem = (remaining_q == SIZE_WIDTH'(1));

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    size_d      = size_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d      = cmd_addr;
          size_d      = cmd_size;
          remaining_d = cmd_size;
          if (cmd_size == '0) begin
            state_d = DRAIN;
            done_d  = 1'b1;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: state_d = STREAM;
      STREAM: begin
        if (consume) begin
          remaining_d = remaining_q - SIZE_WIDTH'(1);
        end
        if ((remaining_q == '0) && xfer) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (size_q == '0) begin
          state_d = IDLE;
        end else if (out_valid && out_ready && out_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      size_q      <= '0;
      remaining_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      remaining_q <= remaining_d;
      done_q      <= done_d;
    end
  end

  tvm_vpi_pack_reg #(
    .READ_WIDTH(READ_WIDTH),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_pack (
    .clk       (clk),
    .rst       (rst),
    .consume   (consume),
    .elem      (read_data_in),
    .final_elem(final_elem),
    .out_ready (out_ready),
    .pack_full (pack_full),
    .xfer      (xfer),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_lanes (out_lanes),
    .out_last  (out_last)
  );

endmodule
